// File: rtl/start_cloud_pio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : start_cloud_pio_pkg
//  Purpose  : Shared types and constants for the HPS-system PIO poller:
//             FSM state encoding, Avalon word width and change-counter width,
//             plus a saturating increment helper.
//  Revision : 1.0  initial release
// ============================================================================
package start_cloud_pio_pkg;

  localparam int AVM_DATA_W = 32;
  localparam int CNT_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD      = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_CMP     = 3'd3,
    ST_WR      = 3'd4
  } state_e;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/start_cloud_pio_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : start_cloud_pio_tick_gen
//  Purpose  : Free-running 0..POLL_DIV-1 counter; tick_o is high for the one
//             cycle the counter sits at its terminal count.
//  Ports    : clk    - system clock
//             reset  - synchronous active-high reset (counter to 0)
//             tick_o - one-cycle poll tick
//  Revision : 1.0  initial release
// ============================================================================
module start_cloud_pio_tick_gen #(
  parameter int POLL_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick_o
);

  localparam int CW = $clog2(POLL_DIV);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == CW'(POLL_DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/start_cloud_hps_system_pio_poller.sv
`default_nettype none
// ============================================================================
//  Module   : start_cloud_hps_system_pio_poller
//  Purpose  : Periodically reads a switch PIO over Avalon-MM and mirrors any
//             changed value (XOR invert_mask) to an output PIO via a write
//             master that honours waitrequest. Reports committed changes as a
//             registered irq pulse and a saturating change counter.
//  Ports    : clk, reset                 - clock, sync active-high reset
//             enable                     - allow new poll transactions
//             invert_mask                - XOR mask applied to written value
//             avm_rd_address/read        - read master command (1-cycle strobe)
//             avm_rd_readdata            - read data, valid cycle after strobe
//             avm_wr_address/write/data  - write master command
//             avm_wr_waitrequest         - write slave stall
//             irq                        - pulse per committed change
//             change_count               - saturating committed-change count
//             overrun                    - sticky: tick arrived while busy
//  Revision : 1.0  initial release
// ============================================================================
module start_cloud_hps_system_pio_poller
  import start_cloud_pio_pkg::*;
#(
  parameter int POLL_DIV = 50000,
  parameter int DATA_W   = 10,
  parameter int IN_ADDR  = 0,
  parameter int OUT_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DATA_W-1:0]     invert_mask,
  output logic [1:0]            avm_rd_address,
  output logic                  avm_rd_read,
  input  logic [AVM_DATA_W-1:0] avm_rd_readdata,
  output logic [1:0]            avm_wr_address,
  output logic                  avm_wr_write,
  output logic [AVM_DATA_W-1:0] avm_wr_writedata,
  input  logic                  avm_wr_waitrequest,
  output logic                  irq,
  output logic [CNT_W-1:0]      change_count,
  output logic                  overrun
);

  logic tick;

  start_cloud_pio_tick_gen #(
    .POLL_DIV (POLL_DIV)
  ) u_tick_gen (
    .clk    (clk),
    .reset  (reset),
    .tick_o (tick)
  );

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  sample_q, sample_d;
  logic [DATA_W-1:0]  last_q, last_d;
  logic               first_q, first_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  // Marks the unconditional post-reset initialisation write, which commits
  // silently (no irq, no count).
  logic               init_wr_q, init_wr_d;
  logic               irq_q, irq_d;
  logic [CNT_W-1:0]   change_count_q, change_count_d;
  logic               overrun_q, overrun_d;

  // Only the low DATA_W bits of the switch word carry information.
  logic unused_rd_hi;
  assign unused_rd_hi = ^avm_rd_readdata[AVM_DATA_W-1:DATA_W];

  // Strobes decode straight from state so a reset edge drops them at once.
  assign avm_rd_read      = (state_q == ST_RD);
  assign avm_rd_address   = avm_rd_read ? 2'(IN_ADDR) : 2'b00;
  assign avm_wr_write     = (state_q == ST_WR);
  assign avm_wr_address   = avm_wr_write ? 2'(OUT_ADDR) : 2'b00;
  assign avm_wr_writedata = {{(AVM_DATA_W-DATA_W){1'b0}}, wr_data_q};
  assign irq              = irq_q;
  assign change_count     = change_count_q;
  assign overrun          = overrun_q;

  always_comb begin
    state_d        = state_q;
    sample_d       = sample_q;
    last_d         = last_q;
    first_d        = first_q;
    wr_data_d      = wr_data_q;
    init_wr_d      = init_wr_q;
    irq_d          = 1'b0;
    change_count_d = change_count_q;
    overrun_d      = overrun_q;

    // Ticks landing mid-transaction are dropped, but remembered.
    if (tick && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick && enable) begin
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        sample_d = avm_rd_readdata[DATA_W-1:0];
        state_d  = ST_CMP;
      end
      ST_CMP: begin
        if ((sample_q != last_q) || first_q) begin
          last_d    = sample_q;
          first_d   = 1'b0;
          init_wr_d = first_q;
          // Mask captured once here and held for the whole write.
          wr_data_d = sample_q ^ invert_mask;
          state_d   = ST_WR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (!avm_wr_waitrequest) begin
          if (!init_wr_q) begin
            irq_d          = 1'b1;
            change_count_d = sat_inc(change_count_q);
          end
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      sample_q       <= '0;
      last_q         <= '0;
      first_q        <= 1'b1;
      wr_data_q      <= '0;
      init_wr_q      <= 1'b0;
      irq_q          <= 1'b0;
      change_count_q <= '0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_q       <= sample_d;
      last_q         <= last_d;
      first_q        <= first_d;
      wr_data_q      <= wr_data_d;
      init_wr_q      <= init_wr_d;
      irq_q          <= irq_d;
      change_count_q <= change_count_d;
      overrun_q      <= overrun_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_start_cloud_hps_system_pio_poller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_start_cloud_hps_system_pio_poller
//  Purpose  : Self-checking bench for the PIO poller. A timeline model keyed
//             on tick acceptance predicts every output each cycle; directed
//             literal checks pin the model's key numbers.
//  Revision : 1.0  initial release
// ============================================================================
module tb_start_cloud_hps_system_pio_poller;

  localparam int POLL_DIV = 8;
  localparam int DATA_W   = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [9:0]  invert_mask;
  logic [1:0]  avm_rd_address;
  logic        avm_rd_read;
  logic [31:0] avm_rd_readdata;
  logic [1:0]  avm_wr_address;
  logic        avm_wr_write;
  logic [31:0] avm_wr_writedata;
  logic        avm_wr_waitrequest;
  logic        irq;
  logic [15:0] change_count;
  logic        overrun;

  logic [9:0]  sw_val;
  int          stall_cfg = 0;
  int          wr_cycles = 0;
  int          force_seq = 0;

  int          errors = 0;
  int          checks = 0;

  start_cloud_hps_system_pio_poller #(
    .POLL_DIV (POLL_DIV),
    .DATA_W   (DATA_W),
    .IN_ADDR  (0),
    .OUT_ADDR (0)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .invert_mask        (invert_mask),
    .avm_rd_address     (avm_rd_address),
    .avm_rd_read        (avm_rd_read),
    .avm_rd_readdata    (avm_rd_readdata),
    .avm_wr_address     (avm_wr_address),
    .avm_wr_write       (avm_wr_write),
    .avm_wr_writedata   (avm_wr_writedata),
    .avm_wr_waitrequest (avm_wr_waitrequest),
    .irq                (irq),
    .change_count       (change_count),
    .overrun            (overrun)
  );

  always #5 clk = ~clk;

  // Slave models: switch word always readable; write slave stalls the first
  // stall_cfg cycles of every write.
  assign avm_rd_readdata    = {22'd0, sw_val};
  assign avm_wr_waitrequest = avm_wr_write && (wr_cycles < stall_cfg);

  always @(posedge clk) begin
    wr_cycles <= avm_wr_write ? wr_cycles + 1 : 0;
  end

  // ---------------- timeline model + per-cycle compare ----------------
  bit          m_valid = 1'b0;
  int          m_cyc, m_off, force_seen = 0;
  bit          m_busy, m_writing, m_first, m_init, m_irq, m_overrun, m_tick;
  logic [9:0]  m_sample, m_last, m_data;
  logic [15:0] m_count;

  always @(negedge clk) begin
    if (force_seq != force_seen) begin
      force_seen = force_seq;
      m_count    = 16'hFFFF;
    end
    if (m_valid) begin
      checks++;
      if ({avm_rd_read, avm_rd_address, avm_wr_write, avm_wr_address,
           avm_wr_writedata, irq, change_count, overrun} !==
          {m_busy && (m_off == 1), 2'b00, m_writing, 2'b00,
           {22'd0, m_data}, m_irq, m_count, m_overrun}) begin
        errors++;
        $display("FAIL model_cmp t=%0t: got rd=%b wr=%b wd=%h irq=%b cnt=%h ovr=%b raddr=%0d waddr=%0d, want rd=%b wr=%b wd=%h irq=%b cnt=%h ovr=%b",
                 $time, avm_rd_read, avm_wr_write, avm_wr_writedata, irq, change_count,
                 overrun, avm_rd_address, avm_wr_address, m_busy && (m_off == 1),
                 m_writing, {22'd0, m_data}, m_irq, m_count, m_overrun);
      end
    end
    if (reset) begin
      m_valid = 1'b1; m_cyc = 0; m_off = 0; m_busy = 0; m_writing = 0;
      m_first = 1; m_init = 0; m_irq = 0; m_overrun = 0;
      m_sample = '0; m_last = '0; m_data = '0; m_count = '0;
    end else if (m_valid) begin
      m_tick = ((m_cyc % POLL_DIV) == POLL_DIV - 1);
      m_irq  = 1'b0;
      if (m_busy) begin
        if (m_tick) m_overrun = 1'b1;
        if (m_off == 2) begin
          m_sample = sw_val;
        end else if (m_off == 3) begin
          if ((m_sample != m_last) || m_first) begin
            m_init    = m_first;
            m_first   = 1'b0;
            m_last    = m_sample;
            m_data    = m_sample ^ invert_mask;
            m_writing = 1'b1;
          end else begin
            m_busy = 1'b0;
          end
        end else if (m_writing && !avm_wr_waitrequest) begin
          if (!m_init) begin
            m_irq = 1'b1;
            if (m_count != 16'hFFFF) m_count = m_count + 16'd1;
          end
          m_busy    = 1'b0;
          m_writing = 1'b0;
        end
        m_off++;
      end else if (m_tick && enable) begin
        m_busy = 1'b1;
        m_off  = 1;
      end
      m_cyc++;
    end
  end

  // ---------------- directed stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Waits (bounded) for the write strobe; returns cycles waited.
  task automatic wait_wr(input string name, output int n);
    n = 0;
    while ((avm_wr_write !== 1'b1) && (n < 40)) begin
      step(1);
      n++;
    end
    checks++;
    if (n >= 40) begin
      errors++;
      $display("FAIL %s: got no write strobe, want one within 40 cycles", name);
    end
  endtask

  // Walks through the write; leaves us in the cycle after the commit.
  task automatic finish_wr(input string name, input logic [31:0] exp_data, output int len);
    len = 0;
    while ((avm_wr_write === 1'b1) && (len < 40)) begin
      chk({name, "_data"}, avm_wr_writedata, exp_data);
      step(1);
      len++;
    end
  endtask

  initial begin
    int n;
    int len;
    reset = 1'b1; enable = 1'b1; invert_mask = '0; sw_val = '0; stall_cfg = 0;
    step(3);
    chk("rst_wr",       {31'd0, avm_wr_write}, 32'd0);
    chk("rst_rd",       {31'd0, avm_rd_read},  32'd0);
    chk("rst_wdata",    avm_wr_writedata,      32'd0);
    chk("rst_count",    {16'd0, change_count}, 32'd0);
    chk("rst_irq_ovr",  {30'd0, irq, overrun}, 32'd0);

    // First poll: unconditional silent write of 0 at tick(7)+4 = cycle 11.
    reset = 1'b0;
    wait_wr("first_wr", n);
    chk("first_wr_latency", n, 32'd11);
    finish_wr("first_wr", 32'h000, len);
    chk("first_irq",   {31'd0, irq}, 32'd0);
    chk("first_count", {16'd0, change_count}, 32'd0);

    // Changed value with mask: 0x2A5 ^ 0x00F = 0x2AA.
    sw_val = 10'h2A5; invert_mask = 10'h00F;
    wait_wr("chg_wr", n);
    chk("chg_wr_latency", n, 32'd7);
    finish_wr("chg_wr", 32'h2AA, len);
    chk("chg_irq",   {31'd0, irq}, 32'd1);
    chk("chg_count", {16'd0, change_count}, 32'd1);
    step(1);
    chk("chg_irq_once", {31'd0, irq}, 32'd0);
    step(12);
    chk("unchanged_count", {16'd0, change_count}, 32'd1);
    chk("no_overrun_yet",  {31'd0, overrun}, 32'd0);

    // Five wait states: strobe held 6 cycles with stable data.
    invert_mask = '0; sw_val = 10'h155; stall_cfg = 5;
    wait_wr("stall_wr", n);
    chk("stall_irq_pre", {31'd0, irq}, 32'd0);
    finish_wr("stall_wr", 32'h155, len);
    chk("stall_len",   len, 32'd6);
    chk("stall_irq",   {31'd0, irq}, 32'd1);
    chk("stall_count", {16'd0, change_count}, 32'd2);

    // Stall longer than POLL_DIV: overrun, then recovery.
    sw_val = 10'h0F0; stall_cfg = 12;
    wait_wr("ovr_wr", n);
    finish_wr("ovr_wr", 32'h0F0, len);
    chk("ovr_len",     len, 32'd13);
    chk("ovr_flag",    {31'd0, overrun}, 32'd1);
    stall_cfg = 0; sw_val = 10'h0F1;
    wait_wr("recover_wr", n);
    finish_wr("recover_wr", 32'h0F1, len);
    chk("recover_count", {16'd0, change_count}, 32'd4);

    // Disabled polling issues nothing; re-enable picks up the change.
    enable = 1'b0; sw_val = 10'h001;
    step(24);
    chk("disabled_count", {16'd0, change_count}, 32'd4);
    enable = 1'b1;
    wait_wr("reen_wr", n);
    finish_wr("reen_wr", 32'h001, len);
    chk("reen_count", {16'd0, change_count}, 32'd5);

    // Reset during a stalled write.
    sw_val = 10'h3FF; stall_cfg = 50;
    wait_wr("rstwr_wr", n);
    step(2);
    reset = 1'b1;
    step(1);
    chk("rstwr_wr_low",  {31'd0, avm_wr_write}, 32'd0);
    chk("rstwr_count",   {16'd0, change_count}, 32'd0);
    chk("rstwr_ovr",     {30'd0, irq, overrun}, 32'd0);
    chk("rstwr_wdata",   avm_wr_writedata, 32'd0);
    reset = 1'b0; stall_cfg = 0;
    wait_wr("post_rst_wr", n);
    chk("post_rst_latency", n, 32'd11);
    finish_wr("post_rst_wr", 32'h3FF, len);
    chk("post_rst_irq",   {31'd0, irq}, 32'd0);
    chk("post_rst_count", {16'd0, change_count}, 32'd0);

    // Saturation: counter pinned at 0xFFFF, irq still pulses.
    force dut.change_count_q = 16'hFFFF;
    force_seq++;
    step(1);
    release dut.change_count_q;
    chk("sat_preset", {16'd0, change_count}, 32'h0000FFFF);
    sw_val = 10'h3FE;
    wait_wr("sat_wr", n);
    finish_wr("sat_wr", 32'h3FE, len);
    chk("sat_irq",   {31'd0, irq}, 32'd1);
    chk("sat_count", {16'd0, change_count}, 32'h0000FFFF);

    step(5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running, want finished");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
